// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
// Steps a JK flip-flop through a latched N-bit target sequence, LSB first.
// For each bit it derives J/K from the flop's present Q with the JK
// excitation table, pulses enable for one cycle, then compares the flop's
// new Q against the target and keeps a saturating mismatch count.
// Per bit the run spends one DRIVE cycle and one CHECK cycle, so a run of
// N bits ends with a one-cycle FINISH, 2N+1 cycles after the accepted start.

module jk_excitation_driver #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          start,
    input  logic [N-1:0]  pattern,
    input  logic          q_in,
    output logic          J,
    output logic          K,
    output logic          enable,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] err_count,
    output logic          last_ok
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] ERR_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_e;

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  pat_q;
    logic          j_q;
    logic          k_q;
    logic          enable_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] err_count_q;
    logic          last_ok_q;

    logic [IW-1:0] idx_nxt_d;
    logic          drive_t_d;
    logic          j_d;
    logic          k_d;
    logic          check_ok_d;
    logic [CW-1:0] err_inc_d;

    // Target of the upcoming DRIVE, its J/K excitation, and the CHECK result.
    always_comb begin
        idx_nxt_d  = idx_q + IW'(1);
        drive_t_d  = 1'b0;
        if (state_q == IDLE) begin
            // pat_q is not yet loaded on the starting edge; take bit 0 live
            drive_t_d = pattern[0];
        end else begin
            drive_t_d = pat_q[idx_nxt_d];
        end
        // Set only when Q must rise, reset only when Q must fall; don't-cares are 0
        j_d        = ~q_in & drive_t_d;
        k_d        = q_in & ~drive_t_d;
        check_ok_d = (q_in == pat_q[idx_q]);
        err_inc_d  = (err_count_q == ERR_MAX) ? err_count_q : (err_count_q + CW'(1));
    end

    // Sequencer: state, bit index, latched pattern and all registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pat_q       <= '0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            last_ok_q   <= 1'b0;
        end else begin
            // Flop controls and done are single-cycle unless re-asserted below
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q       <= pattern;
                        idx_q       <= '0;
                        err_count_q <= '0;
                        last_ok_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        j_q         <= j_d;
                        k_q         <= k_d;
                        enable_q    <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    last_ok_q <= check_ok_d;
                    if (!check_ok_d) begin
                        err_count_q <= err_inc_d;
                    end
                    if (idx_q == IDX_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        // Q is settled here, so the next bit's J/K come from it directly
                        idx_q    <= idx_nxt_d;
                        j_q      <= j_d;
                        k_q      <= k_d;
                        enable_q <= 1'b1;
                        state_q  <= DRIVE;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign enable    = enable_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign last_ok   = last_ok_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver: an 8-bit, CW=4 instance driving a
// modelled JK flop, plus a CW=3 instance whose Q is tied low for saturation.
module tb_jk_excitation_driver;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       stuck = 1'b0;
    logic       preset = 1'b0;
    logic       q_model;
    logic       q_in;

    logic       J, K, enable, busy, done, last_ok;
    logic [3:0] err_count;
    logic       s_J, s_K, s_enable, s_busy, s_done, s_last_ok;
    logic [2:0] s_err_count;

    int edge_cnt = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] err;
        logic       lok;
        int         edge_n;
    } done_t;

    typedef struct {
        logic [2:0] err;
        logic       lok;
    } sdone_t;

    logic [1:0] jk_q[$];
    done_t      done_q[$];
    sdone_t     sdone_q[$];

    assign q_in = stuck ? 1'b0 : q_model;

    jk_excitation_driver #(.N(8), .CW(4)) u_dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .pattern(pattern), .q_in(q_in),
        .J(J), .K(K), .enable(enable), .busy(busy), .done(done),
        .err_count(err_count), .last_ok(last_ok)
    );

    jk_excitation_driver #(.N(8), .CW(3)) u_dut_sat (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .pattern(pattern), .q_in(1'b0),
        .J(s_J), .K(s_K), .enable(s_enable), .busy(s_busy), .done(s_done),
        .err_count(s_err_count), .last_ok(s_last_ok)
    );

    always #5 CLOCK = ~CLOCK;

    // Ideal JK flop with async clear and a synchronous preset hook
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) q_model <= 1'b0;
        else if (preset) q_model <= 1'b1;
        else if (enable && !stuck) begin
            case ({J, K})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

    always @(posedge CLOCK) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: consume expectations whenever a DUT presents a drive or done
    always @(negedge CLOCK) begin : monitor
        logic [1:0] e_jk;
        done_t      e_d;
        sdone_t     e_s;
        if (RESET) begin
            if (enable) begin
                if (jk_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_drive: got J=%0b K=%0b with no expected drive (t=%0t)", J, K, $time);
                end else begin
                    e_jk = jk_q.pop_front();
                    chk("drive_jk", 32'({J, K}), 32'(e_jk));
                    chk("drive_busy", 32'(busy), 32'(1));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got done=1 with no expected run end (t=%0t)", $time);
                end else begin
                    e_d = done_q.pop_front();
                    chk("done_err_count", 32'(err_count), 32'(e_d.err));
                    chk("done_last_ok", 32'(last_ok), 32'(e_d.lok));
                    chk("done_cycle", 32'(edge_cnt), 32'(e_d.edge_n));
                    chk("done_busy", 32'(busy), 32'(0));
                end
            end
            if (s_done) begin
                if (sdone_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_sat_done: got done=1 with no expected run end (t=%0t)", $time);
                end else begin
                    e_s = sdone_q.pop_front();
                    chk("sat_err_count", 32'(s_err_count), 32'(e_s.err));
                    chk("sat_last_ok", 32'(s_last_ok), 32'(e_s.lok));
                    chk("sat_quiet_outs", 32'({s_J, s_K, s_enable, s_busy}), 32'(0));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_main"}, 32'({J, K, enable, busy, done, err_count, last_ok}), 32'(0));
        chk({tag, "_sat"}, 32'({s_J, s_K, s_enable, s_busy, s_done, s_err_count, s_last_ok}), 32'(0));
    endtask

    // One run: jk_exp holds {J,K} for bit i at [2i+1:2i]; abort_c>0 pulls RESET in that cycle
    task automatic run(input logic [7:0] pat, input logic stk, input logic pre,
                       input logic [15:0] jk_exp, input logic [3:0] err, input logic lok,
                       input logic [2:0] serr, input logic slok, input bit repulse,
                       input int abort_c, input int last_c);
        int    e0;
        int    n_drv;
        done_t d;
        sdone_t s;
        if (pre) begin
            @(negedge CLOCK);
            preset = 1'b1;
            @(negedge CLOCK);
            preset = 1'b0;
        end
        @(negedge CLOCK);
        stuck   = stk;
        pattern = pat;
        start   = 1'b1;
        @(posedge CLOCK);
        #1;
        e0    = edge_cnt;
        n_drv = (abort_c == 0) ? 8 : abort_c / 2;
        for (int i = 0; i < n_drv; i++) jk_q.push_back(jk_exp[2*i +: 2]);
        if (abort_c == 0) begin
            d.err = err; d.lok = lok; d.edge_n = e0 + 16;
            done_q.push_back(d);
            s.err = serr; s.lok = slok;
            sdone_q.push_back(s);
        end
        for (int c = 1; c <= last_c; c++) begin
            @(negedge CLOCK);
            start = repulse && (c == 3 || c == 17);
            if (abort_c != 0 && c == abort_c) begin
                RESET = 1'b0;
                #1;
                check_all_zero("abort_outputs");
            end
            if (abort_c != 0 && c == abort_c + 2) RESET = 1'b1;
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge CLOCK);
        #1;
        check_all_zero("reset_state");
        @(negedge CLOCK);
        RESET = 1'b1;

        // Ideal flop from Q=0, 10110010, start re-pulsed in cycles 3 and 17
        run(8'b10110010, 1'b0, 1'b0, 16'h9218, 4'd0, 1'b1, 3'd4, 1'b0, 1'b1, 0, 22);
        // Q stuck at 0, same pattern
        run(8'b10110010, 1'b1, 1'b0, 16'h8A08, 4'd4, 1'b0, 3'd4, 1'b0, 1'b0, 0, 17);
        // Started in the first IDLE cycle; 0xFF against stuck Q saturates the CW=3 count
        run(8'hFF, 1'b1, 1'b0, 16'hAAAA, 4'd8, 1'b0, 3'd7, 1'b0, 1'b0, 0, 20);
        // Preset Q=1, reset pulled during bit 2 CHECK
        run(8'b10110010, 1'b0, 1'b1, 16'h0019, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6, 12);
        // Clean full run after the abort
        run(8'b10110010, 1'b0, 1'b0, 16'h9218, 4'd0, 1'b1, 3'd4, 1'b0, 1'b0, 0, 20);
        // Preset Q=1, all-zero target
        run(8'h00, 1'b0, 1'b1, 16'h0001, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0, 0, 20);

        chk("pending_drives", 32'(jk_q.size()), 32'(0));
        chk("pending_done", 32'(done_q.size()), 32'(0));
        chk("pending_sat_done", 32'(sdone_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
